// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
//   Shared definitions for the systolic MAC processing element.
//   - PE_DW / PE_AW / PE_LW : default operand, accumulator and term-count widths
//   - pe_state_e            : PE control states (IDLE, ACCUM, DONE)
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int PE_DW = 8;   // signed operand width
    localparam int PE_AW = 24;  // signed accumulator / result width (>= 2*DW)
    localparam int PE_LW = 8;   // term-count width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } pe_state_e;

endpackage : pe_pkg

// File: rtl/pe_sat_add.sv
// ---------------------------------------------------------------------------
// pe_sat_add
//   Combinational AW-bit signed adder used for the accumulate step.
//   Build option: SYSTOLIC_MAC_PE_SAT_EN
//     defined   -> result clamps to the signed AW max/min on overflow and
//                  ovf_o reports the clamp
//     undefined -> result wraps modulo 2^AW and ovf_o is constant 0
//
//   Ports
//     a_i, b_i : in  AW  signed addends
//     sum_o    : out AW  signed sum (clamped or wrapped)
//     ovf_o    : out 1   signed overflow occurred and was clamped
// ---------------------------------------------------------------------------
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int AW = PE_AW
) (
    input  logic signed [AW-1:0] a_i,
    input  logic signed [AW-1:0] b_i,
    output logic signed [AW-1:0] sum_o,
    output logic                 ovf_o
);

    logic signed [AW-1:0] raw_sum;

    assign raw_sum = a_i + b_i;

`ifdef SYSTOLIC_MAC_PE_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

    logic raw_ovf;

    // Two's complement overflow: operands share a sign and the sum does not.
    assign raw_ovf = (a_i[AW-1] == b_i[AW-1]) && (raw_sum[AW-1] != a_i[AW-1]);

    always_comb begin
        sum_o = raw_sum;
        if (raw_ovf) begin
            // Direction of the overflow follows the (common) operand sign.
            sum_o = a_i[AW-1] ? SAT_MIN : SAT_MAX;
        end
    end

    assign ovf_o = raw_ovf;
`else
    assign sum_o = raw_sum;
    assign ovf_o = 1'b0;
`endif

endmodule : pe_sat_add

// File: rtl/systolic_mac_pe.sv
// ---------------------------------------------------------------------------
// systolic_mac_pe
//   One processing element of a systolic array. Operands are forwarded to the
//   neighbour PE through a 1-cycle register every cycle, and in parallel the PE
//   computes a dot product of len_i signed operand pairs.
//
//   Build option: SYSTOLIC_MAC_PE_SAT_EN (saturating accumulate + sticky
//   sat_o). Without it the accumulator wraps modulo 2^AW and sat_o stays 0.
//
//   Ports
//     clk_i           : in  1   clock, rising edge
//     reset_i         : in  1   asynchronous, active-high reset
//     start_i         : in  1   begin a new dot product (taken in IDLE, or in
//                               DONE together with result_ready_i)
//     len_i           : in  LW  number of terms, sampled with an accepted start
//     valid_i         : in  1   data_i/weight_i hold a valid pair
//     data_i/weight_i : in  DW  signed operands
//     data_o/weight_o : out DW  registered operand pass-through
//     valid_o         : out 1   registered valid pass-through
//     result_o        : out AW  signed accumulated result
//     result_valid_o  : out 1   result_o valid (held until accepted)
//     result_ready_i  : in  1   consumer accepts result
//     busy_o          : out 1   high in ACCUM or DONE
//     sat_o           : out 1   sticky saturation flag of the current product
//     dbg_state_o     : out 2   current control state (observation only)
//
//   Result handshake: result_valid_o rises when the last term has been
//   accumulated and stays high with result_o stable until a cycle where
//   result_ready_i is also high; that cycle is the transfer. result_ready_i
//   is ignored while result_valid_o is low.
// ---------------------------------------------------------------------------
module systolic_mac_pe
    import pe_pkg::*;
#(
    parameter int DW = PE_DW,
    parameter int AW = PE_AW,
    parameter int LW = PE_LW
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [LW-1:0]        len_i,
    input  logic                 valid_i,
    input  logic signed [DW-1:0] data_i,
    input  logic signed [DW-1:0] weight_i,
    output logic signed [DW-1:0] data_o,
    output logic signed [DW-1:0] weight_o,
    output logic                 valid_o,
    output logic signed [AW-1:0] result_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic                 busy_o,
    output logic                 sat_o,
    output pe_state_e            dbg_state_o
);

    // -----------------------------------------------------------------------
    // Operand pass-through: unconditional 1-cycle delay toward the neighbour.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o   <= '0;
            weight_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            data_o   <= data_i;
            weight_o <= weight_i;
            valid_o  <= valid_i;
        end
    end

    // -----------------------------------------------------------------------
    // Product: full-precision signed DW x DW, then sign-extended to AW.
    // -----------------------------------------------------------------------
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   acc_sum;
    logic                   acc_ovf;

    assign prod     = data_i * weight_i;
    assign prod_ext = AW'(prod);

    // -----------------------------------------------------------------------
    // Control state and datapath registers
    // -----------------------------------------------------------------------
    pe_state_e            state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic                 start_go;

    pe_sat_add #(
        .AW (AW)
    ) u_sat_add (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // A start is taken from IDLE, or from DONE in the same cycle the pending
    // result is accepted, so back-to-back products need no IDLE bubble.
    assign start_go = start_i &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_DONE) && result_ready_i));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        if (start_go) begin
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = len_i;
            // A zero-length product completes immediately with result 0.
            state_d = (len_i != '0) ? ST_ACCUM : ST_DONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Operand pairs are not accumulated while idle.
                end
                ST_ACCUM: begin
                    // Without valid_i the accumulator and count simply hold.
                    if (valid_i) begin
                        acc_d = acc_sum;
                        sat_d = sat_q | acc_ovf;
                        cnt_d = cnt_q - LW'(1);
                        if (cnt_q == LW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (result_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign result_o       = acc_q;
    assign result_valid_o = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);
    assign sat_o          = sat_q;
    assign dbg_state_o    = state_q;

endmodule : systolic_mac_pe

// File: tb/tb_systolic_mac_pe.sv
// ---------------------------------------------------------------------------
// tb_systolic_mac_pe
//   Directed + randomized bench for systolic_mac_pe (DW=8, AW=16, LW=8).
//   Expected results come from a plain-arithmetic dot-product model; the
//   SYSTOLIC_MAC_PE_SAT_EN macro selects clamping or wrapping in the model.
// ---------------------------------------------------------------------------
module tb_systolic_mac_pe;
    import pe_pkg::*;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 8;
    localparam longint AMAX = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (AW - 1));
`ifdef SYSTOLIC_MAC_PE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] weight_i;
    logic [DW-1:0] data_o;
    logic [DW-1:0] weight_o;
    logic          valid_o;
    logic [AW-1:0] result_o;
    logic          result_valid_o;
    logic          result_ready_i;
    logic          busy_o;
    logic          sat_o;
    pe_state_e     dbg_state_o;

    always #5 clk = ~clk;

    systolic_mac_pe #(
        .DW (DW),
        .AW (AW),
        .LW (LW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .len_i          (len_i),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .weight_i       (weight_i),
        .data_o         (data_o),
        .weight_o       (weight_o),
        .valid_o        (valid_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o),
        .sat_o          (sat_o),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    logic [AW-1:0] exp_q[$];
    bit            exp_sat_q[$];
    int            a_q[$];
    int            b_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: dot product with plain integer arithmetic; clamps after each
    // term when saturation is built in, otherwise keeps the low AW bits.
    function automatic void ref_dot(input int a[$], input int b[$],
                                    output logic [AW-1:0] res, output bit sat);
        longint acc;
        acc = 0;
        sat = 1'b0;
        foreach (a[i]) begin
            acc += longint'(a[i]) * longint'(b[i]);
            if (SAT_EN) begin
                if (acc > AMAX) begin
                    acc = AMAX;
                    sat = 1'b1;
                end else if (acc < AMIN) begin
                    acc = AMIN;
                    sat = 1'b1;
                end
            end
        end
        res = acc[AW-1:0];
    endfunction

    task automatic push_expected();
        logic [AW-1:0] r;
        bit            s;
        ref_dot(a_q, b_q, r, s);
        exp_q.push_back(r);
        exp_sat_q.push_back(s);
    endtask

    // ---------------- driver tasks ----------------
    // One clock: inputs were set at a falling edge, captured on the rising
    // edge, outputs examined at the next falling edge.
    task automatic tick();
        logic [DW-1:0] pd;
        logic [DW-1:0] pw;
        logic          pv;
        pd = data_i;
        pw = weight_i;
        pv = valid_i;
        @(posedge clk);
        @(negedge clk);
        check("pass_data", 32'(data_o), 32'(pd));
        check("pass_weight", 32'(weight_o), 32'(pw));
        check("pass_valid", 32'(valid_o), 32'(pv));
    endtask

    task automatic idle_tick();
        valid_i  = 1'b0;
        data_i   = DW'($urandom_range(255, 0));
        weight_i = DW'($urandom_range(255, 0));
        tick();
    endtask

    task automatic send_pair(input int a, input int b);
        data_i   = DW'(a);
        weight_i = DW'(b);
        valid_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
    endtask

    task automatic start_txn(input int len);
        start_i = 1'b1;
        len_i   = LW'(len);
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (result_valid_o !== 1'b1 && n < 50) begin
            idle_tick();
            n++;
        end
        check({tag, "_rvalid"}, 32'(result_valid_o), 32'd1);
    endtask

    task automatic accept_result(input string tag);
        logic [AW-1:0] e;
        bit            s;
        check({tag, "_q_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = exp_sat_q.pop_front();
            check({tag, "_result"}, 32'(result_o), 32'(e));
            check({tag, "_sat"}, 32'(sat_o), 32'(s));
        end
        result_ready_i = 1'b1;
        idle_tick();
        result_ready_i = 1'b0;
        check({tag, "_released"}, 32'(result_valid_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_o"}, 32'(data_o), 32'd0);
        check({tag, "_weight_o"}, 32'(weight_o), 32'd0);
        check({tag, "_valid_o"}, 32'(valid_o), 32'd0);
        check({tag, "_result_o"}, 32'(result_o), 32'd0);
        check({tag, "_rvalid"}, 32'(result_valid_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_sat"}, 32'(sat_o), 32'd0);
        check({tag, "_state"}, 32'(dbg_state_o), 32'(ST_IDLE));
    endtask

    // Full transaction with random gaps and random consumer delay.
    task automatic run_random_txn(input string tag);
        int len;
        int hold;
        len = $urandom_range(6, 1);
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < len; i++) begin
            a_q.push_back(int'($urandom_range(255, 0)) - 128);
            b_q.push_back(int'($urandom_range(255, 0)) - 128);
        end
        push_expected();
        start_txn(len);
        for (int i = 0; i < len; i++) begin
            hold = $urandom_range(2, 0);
            for (int g = 0; g < hold; g++) idle_tick();
            send_pair(a_q[i], b_q[i]);
        end
        wait_result(tag);
        hold = $urandom_range(3, 0);
        for (int g = 0; g < hold; g++) begin
            idle_tick();
            check({tag, "_hold"}, 32'(result_o), 32'(exp_q[0]));
        end
        accept_result(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_i        = 1'b1;
        start_i        = 1'b0;
        len_i          = '0;
        valid_i        = 1'b0;
        data_i         = '0;
        weight_i       = '0;
        result_ready_i = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        idle_tick();
        check("idle_busy", 32'(busy_o), 32'd0);

        // Three consecutive pairs: 6 - 20 - 7 = -21, valid one cycle after last.
        a_q = '{2, -4, 7};
        b_q = '{3, 5, -1};
        push_expected();
        start_txn(3);
        check("dot3_busy", 32'(busy_o), 32'd1);
        send_pair(2, 3);
        send_pair(-4, 5);
        check("dot3_early", 32'(result_valid_o), 32'd0);
        send_pair(7, -1);
        check("dot3_latency", 32'(result_valid_o), 32'd1);
        accept_result("dot3");

        // Four (1,1) pairs with 2-cycle gaps; a start during ACCUM is ignored.
        a_q = '{1, 1, 1, 1};
        b_q = '{1, 1, 1, 1};
        push_expected();
        start_txn(4);
        for (int i = 0; i < 4; i++) begin
            send_pair(1, 1);
            if (i < 3) begin
                start_i = 1'b1;
                len_i   = LW'(1);
                idle_tick();
                start_i = 1'b0;
                idle_tick();
                check("gap_busy", 32'(busy_o), 32'd1);
                check("gap_rvalid", 32'(result_valid_o), 32'd0);
            end
        end
        check("gap_done", 32'(result_valid_o), 32'd1);
        accept_result("gaps");

        // Zero-length product; pairs in DONE and IDLE are not accumulated.
        a_q.delete();
        b_q.delete();
        push_expected();
        start_txn(0);
        check("len0_rvalid", 32'(result_valid_o), 32'd1);
        send_pair(5, 5);
        send_pair(-9, 3);
        check("len0_held", 32'(result_valid_o), 32'd1);
        accept_result("len0");
        send_pair(9, 9);
        send_pair(11, 2);
        check("idle_pairs_busy", 32'(busy_o), 32'd0);
        a_q = '{3};
        b_q = '{3};
        push_expected();
        start_txn(1);
        send_pair(3, 3);
        wait_result("after_idle");
        accept_result("after_idle");

        // Overflow: three (-128,-128) terms of 16384 in a 16-bit accumulator.
        a_q = '{-128, -128, -128};
        b_q = '{-128, -128, -128};
        push_expected();
        start_txn(3);
        send_pair(-128, -128);
        send_pair(-128, -128);
        send_pair(-128, -128);
        wait_result("ovf");
        check("ovf_value", 32'(result_o), SAT_EN ? 32'h7FFF : 32'hC000);
        accept_result("ovf");
        a_q = '{1};
        b_q = '{2};
        push_expected();
        start_txn(1);
        check("sat_cleared", 32'(sat_o), 32'd0);
        send_pair(1, 2);
        wait_result("post_ovf");
        accept_result("post_ovf");

        // Consumer stalls 5 cycles, then accepts together with a new start.
        a_q = '{10, 4};
        b_q = '{-3, 4};
        push_expected();
        start_txn(2);
        send_pair(10, -3);
        send_pair(4, 4);
        wait_result("stall");
        for (int i = 0; i < 5; i++) begin
            idle_tick();
            check("stall_rvalid", 32'(result_valid_o), 32'd1);
            check("stall_result", 32'(result_o), 32'(exp_q[0]));
        end
        check("stall_final", 32'(result_o), 32'(exp_q.pop_front()));
        void'(exp_sat_q.pop_front());
        result_ready_i = 1'b1;
        start_i        = 1'b1;
        len_i          = LW'(2);
        idle_tick();
        result_ready_i = 1'b0;
        start_i        = 1'b0;
        check("b2b_rvalid", 32'(result_valid_o), 32'd0);
        check("b2b_busy", 32'(busy_o), 32'd1);
        check("b2b_state", 32'(dbg_state_o), 32'(ST_ACCUM));
        a_q = '{-7, 5};
        b_q = '{6, 5};
        push_expected();
        send_pair(-7, 6);
        send_pair(5, 5);
        wait_result("b2b");
        accept_result("b2b");

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            run_random_txn($sformatf("rand%0d", t));
        end

        // Asynchronous reset in the middle of an accumulation.
        start_txn(5);
        send_pair(50, 50);
        send_pair(60, -60);
        send_pair(90, 33);
        check("pre_reset_data", 32'(data_o), 32'd90);
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        reset_i = 1'b0;
        send_pair(1, 1);
        send_pair(2, 2);
        for (int i = 0; i < 3; i++) begin
            idle_tick();
            check("post_reset_rvalid", 32'(result_valid_o), 32'd0);
            check("post_reset_busy", 32'(busy_o), 32'd0);
        end
        a_q = '{-3, 8};
        b_q = '{4, 8};
        push_expected();
        start_txn(2);
        send_pair(-3, 4);
        send_pair(8, 8);
        wait_result("post_reset");
        accept_result("post_reset");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_systolic_mac_pe

// File: doc/systolic_mac_pe.md
SYSTOLIC_MAC_PE -- requirements
Module: systolic_mac_pe

Interface
REQ-001 SHALL have parameter DW, default 8, signed operand width.
REQ-002 SHALL have parameter AW, default 24, signed accumulator/result width; AW >= 2*DW.
REQ-003 SHALL have parameter LW, default 8, width of term-count input.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 reset_i  in  1  reset, asynchronous, active-high.
REQ-006 start_i  in  1  pulse: begin a new dot product of len_i terms.
REQ-007 len_i  in  LW  term count, sampled on accepted start_i.
REQ-008 valid_i  in  1  data_i/weight_i carry a valid operand pair.
REQ-009 data_i, weight_i  in  DW each  signed operands.
REQ-010 data_o, weight_o, valid_o  out  DW/DW/1  registered pass-through to neighbour PEs.
REQ-011 result_o  out  AW  signed accumulated result.
REQ-012 result_valid_o  out  1  result_o valid, held until result_ready_i.
REQ-013 result_ready_i  in  1  consumer accepts result.
REQ-014 busy_o  out  1  high in ACCUM or DONE.
REQ-015 sat_o  out  1  sticky saturation flag for current dot product.

Function
REQ-016 Pass-through SHALL be a 1-cycle register of data_i/weight_i/valid_i every cycle, independent of FSM state.
REQ-017 Product SHALL be full-precision signed DW x DW -> 2*DW, sign-extended to AW before accumulation.
REQ-018 FSM states IDLE, ACCUM, DONE; reset state IDLE.
REQ-019 IDLE + start_i: acc<=0, sat<=0, cnt<=len_i; next ACCUM if len_i!=0, else DONE with result 0.
REQ-020 ACCUM: each valid_i cycle acc<=acc+product, cnt<=cnt-1; valid_i with cnt==1 -> DONE.
REQ-021 ACCUM without valid_i: acc and cnt SHALL hold.
REQ-022 start_i SHALL be ignored in ACCUM; valid_i SHALL be ignored (not accumulated) in IDLE and DONE.
REQ-023 DONE: result_valid_o=1, result_o=acc stable until result_ready_i; handshake completes on the cycle both are high.
REQ-024 DONE with result_ready_i and start_i same cycle: result accepted and new start taken per REQ-019 (no IDLE bubble).
REQ-025 DONE with result_ready_i, no start_i -> IDLE.
REQ-026 Latency: result_valid_o rises the cycle after the last valid term is accumulated.

Reset
REQ-027 reset_i SHALL force state IDLE, acc, cnt, result_o, data_o, weight_o to 0; valid_o, result_valid_o, sat_o, busy_o to 0.
REQ-028 Reset mid-ACCUM or mid-DONE SHALL discard the partial/pending result; no result_valid_o afterwards until a new start completes.

Configuration
REQ-029 With SYSTOLIC_MAC_PE_SAT_EN defined: accumulation SHALL clamp to signed AW max/min on overflow and set sat_o until next accepted start_i.
REQ-030 Without SYSTOLIC_MAC_PE_SAT_EN: accumulation SHALL wrap modulo 2^AW; sat_o tied 0.

Structure
REQ-031 Package pe_pkg SHALL hold the FSM state enum (IDLE/ACCUM/DONE) and default DW/AW/LW constants.
REQ-032 Sub-module pe_sat_add (combinational AW-bit signed add, saturating per macro) SHALL implement the accumulate step.

Verification
REQ-033 start_i, len_i=3, pairs (2,3),(-4,5),(7,-1) consecutive -> result_o=-21, result_valid_o one cycle after third pair.
REQ-034 len_i=4 with valid_i gaps of 2 cycles between pairs (1,1)x4 -> result_o=4; acc holds during gaps.
REQ-035 len_i=0 -> result_valid_o next cycle, result_o=0; valid_i pairs in IDLE/DONE not accumulated; pass-through always 1-cycle delayed.
REQ-036 DW=8, AW=16, len_i=3 of (-128,-128): SAT_EN -> result_o=32767, sat_o=1; no SAT_EN -> wrapped 0xC000 (-16384), sat_o=0.
REQ-037 result_ready_i low 5 cycles -> result_o stable; then ready+start same cycle -> new ACCUM with acc=0, no IDLE bubble.
REQ-038 reset_i asserted mid-ACCUM (asynchronous, between edges) -> all outputs 0 immediately; no result_valid_o until next full transaction.
